fpu_wb_csr: RTL and testbench
=============================

Name: fpu_wb_csr

Overview:
- Wishbone-slave register block that sits between the management SoC bus and the single-precision FPU core inside the user project area.
- Firmware writes operands a/b/c, the operation word (one-hot op code plus valid bit) and the rounding mode.
- The FPU result and exception flags are captured back into read-only registers.
- Every register is memory-mapped at BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the register window.
- OP_W, 12, width of the one-hot operation code.
- FLAG_W, 5, width of the IEEE exception-flag vector (NV, DZ, OF, UF, NX).

Ports:
- wb_clk_i  in  1  single system clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- a  out  32  operand a to the FPU.
- b  out  32  operand b.
- c  out  32  operand c (MAC addend).
- op_in  out  OP_W  one-hot operation.
- valid_in  out  1  operation-valid level.
- start  out  1  one-cycle start pulse.
- round_mode  out  3  rounding mode.
- result_i  in  32  FPU result.
- flags_i  in  FLAG_W  FPU exception flags.
- done_i  in  1  FPU result-valid pulse.

Behaviour:
- Address decode: hit when adr[31:8] equals BASE_ADDR[31:8]; offset is adr[7:0]. Misses get no ack and no register side effect.
- Register map:
  - 0x00 a (RW)
  - 0x04 b (RW)
  - 0x08 c (RW)
  - 0x0C result (RO)
  - 0x10 flags (RO, bits[FLAG_W-1:0])
  - 0x14 status (bit0 done, write-1-to-clear)
  - 0x1C operation (RW): bits[11:0]=op_in, bit12=valid_in, bits[31:13] read 0
  - 0x24 round_mode (RW, bits[2:0])
  - Other offsets read 0; writes to them are ignored.
- Bus timing:
  - A transfer starts on cyc&stb&!ack at a rising edge.
  - wbs_ack_o is asserted for exactly one cycle on the following edge.
  - Writes take effect on that same edge, so the output port equals the written data before the next negedge.
  - Read data is registered with ack.
  - Back-to-back transfers each get their own ack (minimum 2 cycles per transfer).
- Byte enables: each wbs_sel_i[k] gates byte k of writable registers.
- Output ports: a, b, c, op_in, valid_in and round_mode are direct register outputs.
- start: one-cycle pulse the cycle after valid_in transitions 0->1. Rewriting valid_in=1 while it is already 1 does not retrigger.
- On done_i:
  - result <= result_i, flags <= flags_i, status.done <= 1.
  - valid_in is not auto-cleared; firmware clears it.
- Simultaneous done_i and a W1C write to status: set wins.
- Reset: all registers, wbs_ack_o, wbs_dat_o and start are 0. Reset mid-transfer aborts it with no ack.

Decomposition:
- Shared package fpu_pkg:
  - register offset constants (OFF_A…OFF_RM)
  - op one-hot bit positions (add, sub, mul, div, sqrt, mac, min/max, compare, int/float conversions)
  - rounding-mode encodings (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4)
  - flag bit indices
- No sub-module; the whole block is one flat module.

Test Plan:
- Reset, then write 0x00=0x40490FDB -> a==0x40490FDB two negedges after the address appears; ack is high for exactly 1 cycle.
- Write 0x04=0x3F800000, 0x24=0x1, then 0x1C=0x0000_1008 (div, valid) -> b==0x3F800000, round_mode==1, {19'b0,valid_in,op_in}==0x1008, and start pulses once.
- done_i with result_i=0x40490FDB, flags_i=5'b00001 -> reading 0x0C returns 0x40490FDB, 0x10 returns 0x01, 0x14 returns 0x1. Writing 1 to 0x14 clears it.
- Write 0x00=0xFFFFFFFF with sel=4'b0010 after a=0 -> a==0x0000FF00. A write to address 0x30000100 produces no ack and no change.
- done_i coincident with a W1C write to 0x14 -> done stays 1. Asserting wb_rst_i mid-transfer -> no ack, all outputs 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants for the FPU Wishbone register block: register offsets,
// op one-hot bit positions, rounding modes and flag indices.
package fpu_pkg;

  localparam logic [7:0] OFF_A      = 8'h00;
  localparam logic [7:0] OFF_B      = 8'h04;
  localparam logic [7:0] OFF_C      = 8'h08;
  localparam logic [7:0] OFF_RES    = 8'h0C;
  localparam logic [7:0] OFF_FLAGS  = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;
  localparam logic [7:0] OFF_OP     = 8'h1C;
  localparam logic [7:0] OFF_RM     = 8'h24;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_MUL  = 2;
  localparam int unsigned OP_DIV  = 3;
  localparam int unsigned OP_SQRT = 4;
  localparam int unsigned OP_MAC  = 5;
  localparam int unsigned OP_MIN  = 6;
  localparam int unsigned OP_MAX  = 7;
  localparam int unsigned OP_CEQ  = 8;
  localparam int unsigned OP_CLT  = 9;
  localparam int unsigned OP_F2I  = 10;
  localparam int unsigned OP_I2F  = 11;

  typedef enum logic [2:0] {
    RmRne = 3'd0,
    RmRtz = 3'd1,
    RmRdn = 3'd2,
    RmRup = 3'd3,
    RmRmm = 3'd4
  } round_mode_e;

  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  // Merge a write into a register, byte k taken from i_new only when sel[k] is set.
  function automatic logic [31:0] apply_sel(input logic [31:0] i_old, input logic [31:0] i_new,
                                            input logic [3:0] i_sel);
    logic [31:0] w_res;
    for (int k = 0; k < 4; k++) begin
      w_res[8*k +: 8] = i_sel[k] ? i_new[8*k +: 8] : i_old[8*k +: 8];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/fpu_wb_csr.sv
// Wishbone slave register window in front of the single-precision FPU core:
// operand/op/rounding registers out, result/flags/done captured back.
module fpu_wb_csr
  import fpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned OP_W      = 12,
  parameter int unsigned FLAG_W    = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [31:0]       a,
  output logic [31:0]       b,
  output logic [31:0]       c,
  output logic [OP_W-1:0]   op_in,
  output logic              valid_in,
  output logic              start,
  output logic [2:0]        round_mode,
  input  logic [31:0]       result_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic              done_i
);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [31:0]       r_a, r_b, r_c, r_res;
  logic [OP_W-1:0]   r_op;
  logic              r_valid;
  logic              r_start;
  logic [2:0]        r_rm;
  logic [FLAG_W-1:0] r_flags;
  logic              r_done;

  logic        w_hit, w_req, w_wr;
  logic [7:0]  w_off;
  logic [31:0] w_rdata;
  logic [31:0] w_op_word, w_op_nxt, w_rm_nxt;
  logic        w_valid_nxt;

  assign w_off = wbs_adr_i[7:0];
  assign w_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // The !ack term forces an idle cycle so every transfer gets its own ack.
  assign w_req = wbs_cyc_i & wbs_stb_i & ~r_ack & w_hit;
  assign w_wr  = w_req & wbs_we_i;

  assign w_op_word   = {{(31 - OP_W){1'b0}}, r_valid, r_op};
  assign w_op_nxt    = apply_sel(w_op_word, wbs_dat_i, wbs_sel_i);
  assign w_rm_nxt    = apply_sel({29'b0, r_rm}, wbs_dat_i, wbs_sel_i);
  assign w_valid_nxt = (w_wr && w_off == OFF_OP) ? w_op_nxt[OP_W] : r_valid;

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_A:      w_rdata = r_a;
      OFF_B:      w_rdata = r_b;
      OFF_C:      w_rdata = r_c;
      OFF_RES:    w_rdata = r_res;
      OFF_FLAGS:  w_rdata = {{(32 - FLAG_W){1'b0}}, r_flags};
      OFF_STATUS: w_rdata = {31'b0, r_done};
      OFF_OP:     w_rdata = w_op_word;
      OFF_RM:     w_rdata = {29'b0, r_rm};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_rm    <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_valid <= w_valid_nxt;
      r_start <= w_valid_nxt & ~r_valid;
      if (w_req) r_dat <= w_rdata;
      if (w_wr) begin
        case (w_off)
          OFF_A:      r_a  <= apply_sel(r_a, wbs_dat_i, wbs_sel_i);
          OFF_B:      r_b  <= apply_sel(r_b, wbs_dat_i, wbs_sel_i);
          OFF_C:      r_c  <= apply_sel(r_c, wbs_dat_i, wbs_sel_i);
          OFF_STATUS: if (wbs_sel_i[0] && wbs_dat_i[0]) r_done <= 1'b0;
          OFF_OP:     r_op <= w_op_nxt[OP_W-1:0];
          OFF_RM:     r_rm <= w_rm_nxt[2:0];
          default:    ;
        endcase
      end
      // Placed after the bus write so a coincident W1C loses to the set.
      if (done_i) begin
        r_res   <= result_i;
        r_flags <= flags_i;
        r_done  <= 1'b1;
      end
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign a          = r_a;
  assign b          = r_b;
  assign c          = r_c;
  assign op_in      = r_op;
  assign valid_in   = r_valid;
  assign start      = r_start;
  assign round_mode = r_rm;

endmodule

// File: tb/tb_fpu_wb_csr.sv
// Self-checking bench for fpu_wb_csr: directed scenarios plus a randomized
// run against a register-map reference model.
module tb_fpu_wb_csr;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat_o;
  logic [31:0] a, b, c;
  logic [11:0] op_in;
  logic        valid_in, start;
  logic [2:0]  round_mode;
  logic [31:0] result_i = '0;
  logic [4:0]  flags_i = '0;
  logic        done_i = 1'b0;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  fpu_wb_csr dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat_o),
    .a         (a),
    .b         (b),
    .c         (c),
    .op_in     (op_in),
    .valid_in  (valid_in),
    .start     (start),
    .round_mode(round_mode),
    .result_i  (result_i),
    .flags_i   (flags_i),
    .done_i    (done_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start) start_cnt++;

  // One bus transfer; returns read data and the number of acks seen (including any stray one).
  task automatic wb_xfer(input logic i_we, input logic [31:0] i_adr, input logic [31:0] i_dat,
                         input logic [3:0] i_sel, output logic [31:0] o_rdat, output int o_acks);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = i_we; adr = i_adr; wdat = i_dat; sel = i_sel;
    o_acks = 0;
    o_rdat = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        o_acks++;
        o_rdat = rdat_o;
        break;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    if (ack) o_acks++;
  endtask

  task automatic pulse_done(input logic [31:0] i_res, input logic [4:0] i_flags);
    @(negedge clk);
    done_i = 1'b1; result_i = i_res; flags_i = i_flags;
    @(negedge clk);
    done_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int n;
    do_reset();
    checks++;
    if ({ack, rdat_o, a, b, c, op_in, valid_in, start, round_mode} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: a=%h b=%h c=%h op=%h v=%b st=%b rm=%h ack=%b dat=%h required all 0",
               a, b, c, op_in, valid_in, start, round_mode, ack, rdat_o);
    end
    for (int off = 0; off <= 'h24; off += 4) begin
      wb_xfer(1'b0, BASE + off, '0, 4'hF, rd, n);
      checks++;
      if (rd !== 32'h0 || n != 1) begin
        failures++;
        $display("FAIL reset_read off=%h: data=%h acks=%0d required 0/1", off, rd, n);
      end
    end
  endtask

  task automatic test_write_a();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h4049_0FDB; sel = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1 || a !== 32'h4049_0FDB) begin
      failures++;
      $display("FAIL write_a_first_edge: ack=%b a=%h required 1/40490fdb", ack, a);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || a !== 32'h4049_0FDB) begin
      failures++;
      $display("FAIL write_a_ack_width: ack=%b a=%h required 0/40490fdb", ack, a);
    end
  endtask

  task automatic test_div_start();
    logic [31:0] rd;
    int n, base_cnt;
    base_cnt = start_cnt;
    wb_xfer(1'b1, BASE + 32'h04, 32'h3F80_0000, 4'hF, rd, n);
    wb_xfer(1'b1, BASE + 32'h24, 32'h1, 4'hF, rd, n);
    wb_xfer(1'b1, BASE + 32'h1C, 32'h0000_1008, 4'hF, rd, n);
    repeat (3) @(negedge clk);
    checks++;
    if (b !== 32'h3F80_0000 || round_mode !== 3'd1 || {19'b0, valid_in, op_in} !== 32'h1008) begin
      failures++;
      $display("FAIL div_setup: b=%h rm=%0d op=%h required 3f800000/1/1008", b, round_mode,
               {19'b0, valid_in, op_in});
    end
    checks++;
    if (start_cnt - base_cnt != 1) begin
      failures++;
      $display("FAIL start_pulse: pulses=%0d required 1", start_cnt - base_cnt);
    end
    wb_xfer(1'b1, BASE + 32'h1C, 32'h0000_1008, 4'hF, rd, n);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - base_cnt != 1) begin
      failures++;
      $display("FAIL start_no_retrigger: pulses=%0d required 1", start_cnt - base_cnt);
    end
    wb_xfer(1'b0, BASE + 32'h1C, '0, 4'hF, rd, n);
    checks++;
    if (rd !== 32'h1008) begin
      failures++;
      $display("FAIL op_readback: data=%h required 00001008", rd);
    end
  endtask

  task automatic test_done();
    logic [31:0] rd;
    int n;
    pulse_done(32'h4049_0FDB, 5'b00001);
    wb_xfer(1'b0, BASE + 32'h0C, '0, 4'hF, rd, n);
    checks++;
    if (rd !== 32'h4049_0FDB) begin
      failures++;
      $display("FAIL done_result: data=%h required 40490fdb", rd);
    end
    wb_xfer(1'b0, BASE + 32'h10, '0, 4'hF, rd, n);
    checks++;
    if (rd !== 32'h1) begin
      failures++;
      $display("FAIL done_flags: data=%h required 00000001", rd);
    end
    wb_xfer(1'b0, BASE + 32'h14, '0, 4'hF, rd, n);
    checks++;
    if (rd !== 32'h1) begin
      failures++;
      $display("FAIL done_status: data=%h required 00000001", rd);
    end
    checks++;
    if (valid_in !== 1'b1) begin
      failures++;
      $display("FAIL valid_kept: valid_in=%b required 1", valid_in);
    end
    wb_xfer(1'b1, BASE + 32'h14, 32'h1, 4'hF, rd, n);
    wb_xfer(1'b0, BASE + 32'h14, '0, 4'hF, rd, n);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL status_w1c: data=%h required 00000000", rd);
    end
  endtask

  task automatic test_byte_sel_miss();
    logic [31:0] rd;
    int n;
    wb_xfer(1'b1, BASE, 32'h0, 4'hF, rd, n);
    wb_xfer(1'b1, BASE, 32'hFFFF_FFFF, 4'b0010, rd, n);
    checks++;
    if (a !== 32'h0000_FF00) begin
      failures++;
      $display("FAIL byte_sel: a=%h required 0000ff00", a);
    end
    wb_xfer(1'b1, 32'h3000_0100, 32'h1234_5678, 4'hF, rd, n);
    checks++;
    if (n != 0 || a !== 32'h0000_FF00) begin
      failures++;
      $display("FAIL addr_miss: acks=%0d a=%h required 0/0000ff00", n, a);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd;
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h14; wdat = 32'h1; sel = 4'hF;
    done_i = 1'b1; result_i = 32'hC000_0000; flags_i = 5'b10000;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; done_i = 1'b0;
    wb_xfer(1'b0, BASE + 32'h14, '0, 4'hF, rd, n);
    checks++;
    if (rd !== 32'h1) begin
      failures++;
      $display("FAIL w1c_collision: status=%h required 00000001", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n;
    wb_xfer(1'b0, BASE + 32'h14, '0, 4'hF, rd, n);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h08; wdat = 32'hDEAD_BEEF; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ack, rdat_o, a, b, c, op_in, valid_in, start, round_mode} !== '0) begin
      failures++;
      $display("FAIL reset_mid: ack=%b dat=%h a=%h b=%h c=%h op=%h v=%b rm=%h required all 0",
               ack, rdat_o, a, b, c, op_in, valid_in, round_mode);
    end
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || c !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_after: ack=%b c=%h required 0/0", ack, c);
    end
  endtask

  // Reference model: register array indexed by word offset, with per-offset writable masks.
  logic [31:0] m_reg [0:15];

  function automatic logic [31:0] rw_mask(input int idx);
    case (idx)
      0, 1, 2: return 32'hFFFF_FFFF;
      7:       return 32'h0000_1FFF;
      9:       return 32'h0000_0007;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] rd, d, bm;
    logic [3:0]  s;
    int n, idx, kind, exp_starts, base_cnt;
    logic prev_v;
    do_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    exp_starts = 0;
    base_cnt = start_cnt;
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 9);
      idx = (kind == 9) ? 5 : $urandom_range(0, 11);
      d = $urandom;
      s = 4'($urandom);
      if (kind <= 4 || kind == 9) begin
        wb_xfer(1'b1, BASE + 32'(idx * 4), d, s, rd, n);
        prev_v = m_reg[7][12];
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & rw_mask(idx);
        m_reg[idx] = (m_reg[idx] & ~bm) | (d & bm);
        if (idx == 5 && s[0] && d[0]) m_reg[5] = 32'h0;
        if (!prev_v && m_reg[7][12]) exp_starts++;
        checks++;
        if (n != 1 || a !== m_reg[0] || b !== m_reg[1] || c !== m_reg[2] ||
            {valid_in, op_in} !== m_reg[7][12:0] || round_mode !== m_reg[9][2:0]) begin
          failures++;
          $display("FAIL rand_write it=%0d off=%h: acks=%0d a=%h b=%h c=%h op=%h rm=%h required 1/%h/%h/%h/%h/%h",
                   it, idx * 4, n, a, b, c, {valid_in, op_in}, round_mode,
                   m_reg[0], m_reg[1], m_reg[2], m_reg[7][12:0], m_reg[9][2:0]);
        end
      end else if (kind <= 7) begin
        wb_xfer(1'b0, BASE + 32'(idx * 4), '0, 4'hF, rd, n);
        checks++;
        if (n != 1 || rd !== m_reg[idx]) begin
          failures++;
          $display("FAIL rand_read it=%0d off=%h: acks=%0d data=%h required 1/%h",
                   it, idx * 4, n, rd, m_reg[idx]);
        end
      end else begin
        pulse_done(d, 5'(s ^ 4'($urandom)));
        m_reg[3] = d;
        m_reg[4] = {27'b0, flags_i};
        m_reg[5] = 32'h1;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - base_cnt != exp_starts) begin
      failures++;
      $display("FAIL rand_starts: pulses=%0d required %0d", start_cnt - base_cnt, exp_starts);
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_div_start();
    test_done();
    test_byte_sel_miss();
    test_w1c_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
